// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer: arbitrates IRQs, exceptions and MRET, flushes and drains the
// pipeline, pulses the CSR file once, then redirects fetch to mtvec or mepc.
module trap_sequencer #(
   parameter int XLEN       = 32,
   parameter int MEIP_CAUSE = 11,
   parameter int MTIP_CAUSE = 7,
   parameter int DRAIN_MAX  = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            irq_ext_i,
   input  logic            irq_timer_i,
   input  logic            mstatus_mie_i,
   input  logic            exc_valid_i,
   input  logic [3:0]      exc_code_i,
   input  logic [XLEN-1:0] exc_pc_i,
   input  logic [XLEN-1:0] exc_addr_i,
   input  logic            mret_i,
   input  logic [XLEN-1:0] commit_pc_i,
   input  logic            pipe_idle_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   output logic            stall_o,
   output logic            flush_o,
   output logic            csr_ext_intr_o,
   output logic            csr_timer_intr_o,
   output logic            csr_exc_valid_o,
   output logic [3:0]      csr_exception_o,
   output logic [XLEN-1:0] csr_exception_pc_o,
   output logic [XLEN-1:0] csr_exception_addr_o,
   output logic            csr_mret_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            drain_timeout_o,
   output logic [2:0]      dbg_state_o
);

   localparam int CW = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FLUSH    = 3'd1,
      S_DRAIN    = 3'd2,
      S_COMMIT   = 3'd3,
      S_REDIRECT = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      K_EXT   = 2'd0,
      K_TIMER = 2'd1,
      K_EXC   = 2'd2,
      K_MRET  = 2'd3
   } kind_e;

   state_e            state_q, state_d;
   kind_e             kind_q, kind_d;
   logic [3:0]        cause_q, cause_d;
   logic [XLEN-1:0]   epc_q, epc_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   tvec_base;

   assign tvec_base = {mtvec_i[XLEN-1:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         kind_q  <= K_EXT;
         cause_q <= '0;
         epc_q   <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         cause_q <= cause_d;
         epc_q   <= epc_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      kind_d           = kind_q;
      cause_d          = cause_q;
      epc_d            = epc_q;
      addr_d           = addr_q;
      cnt_d            = cnt_q;
      flush_o          = 1'b0;
      csr_ext_intr_o   = 1'b0;
      csr_timer_intr_o = 1'b0;
      csr_exc_valid_o  = 1'b0;
      csr_mret_o       = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      drain_timeout_o  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Fixed priority; anything not chosen this edge is dropped.
            if (irq_ext_i && mstatus_mie_i) begin
               kind_d  = K_EXT;
               cause_d = 4'(MEIP_CAUSE);
               epc_d   = commit_pc_i;
               addr_d  = '0;
               state_d = S_FLUSH;
            end else if (irq_timer_i && mstatus_mie_i) begin
               kind_d  = K_TIMER;
               cause_d = 4'(MTIP_CAUSE);
               epc_d   = commit_pc_i;
               addr_d  = '0;
               state_d = S_FLUSH;
            end else if (exc_valid_i) begin
               kind_d  = K_EXC;
               cause_d = exc_code_i;
               epc_d   = exc_pc_i;
               addr_d  = exc_addr_i;
               state_d = S_FLUSH;
            end else if (mret_i) begin
               kind_d  = K_MRET;
               cause_d = '0;
               epc_d   = '0;
               addr_d  = '0;
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            flush_o = 1'b1;
            cnt_d   = '0;
            state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (pipe_idle_i) begin
               cnt_d   = '0;
               state_d = S_COMMIT;
            end else if (cnt_q == CW'(DRAIN_MAX - 1)) begin
               drain_timeout_o = 1'b1;
               cnt_d           = '0;
               state_d         = S_COMMIT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_COMMIT: begin
            csr_ext_intr_o   = (kind_q == K_EXT);
            csr_timer_intr_o = (kind_q == K_TIMER);
            csr_exc_valid_o  = (kind_q == K_EXC);
            csr_mret_o       = (kind_q == K_MRET);
            state_d          = S_REDIRECT;
         end
         S_REDIRECT: begin
            // mtvec/mepc are read here, after the CSR file has absorbed the COMMIT pulse.
            redirect_valid_o = 1'b1;
            case (kind_q)
               K_MRET:  redirect_pc_o = mepc_i;
               K_EXC:   redirect_pc_o = tvec_base;
               default: redirect_pc_o = (mtvec_i[1:0] == 2'b01) ?
                                        tvec_base + (XLEN'(cause_q) << 2) : tvec_base;
            endcase
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign stall_o              = (state_q != S_IDLE);
   assign csr_exception_o      = cause_q;
   assign csr_exception_pc_o   = epc_q;
   assign csr_exception_addr_o = addr_q;
   assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: hand-computed expectations for each trap kind,
// drain timeout, arbitration, vectoring and asynchronous reset.
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        irq_ext_i, irq_timer_i, mstatus_mie_i;
   logic        exc_valid_i;
   logic [3:0]  exc_code_i;
   logic [31:0] exc_pc_i, exc_addr_i;
   logic        mret_i;
   logic [31:0] commit_pc_i;
   logic        pipe_idle_i;
   logic [31:0] mtvec_i, mepc_i;
   logic        stall_o, flush_o;
   logic        csr_ext_intr_o, csr_timer_intr_o, csr_exc_valid_o, csr_mret_o;
   logic [3:0]  csr_exception_o;
   logic [31:0] csr_exception_pc_o, csr_exception_addr_o;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;
   logic        drain_timeout_o;
   logic [2:0]  dbg_state_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   trap_sequencer dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .irq_ext_i            (irq_ext_i),
      .irq_timer_i          (irq_timer_i),
      .mstatus_mie_i        (mstatus_mie_i),
      .exc_valid_i          (exc_valid_i),
      .exc_code_i           (exc_code_i),
      .exc_pc_i             (exc_pc_i),
      .exc_addr_i           (exc_addr_i),
      .mret_i               (mret_i),
      .commit_pc_i          (commit_pc_i),
      .pipe_idle_i          (pipe_idle_i),
      .mtvec_i              (mtvec_i),
      .mepc_i               (mepc_i),
      .stall_o              (stall_o),
      .flush_o              (flush_o),
      .csr_ext_intr_o       (csr_ext_intr_o),
      .csr_timer_intr_o     (csr_timer_intr_o),
      .csr_exc_valid_o      (csr_exc_valid_o),
      .csr_exception_o      (csr_exception_o),
      .csr_exception_pc_o   (csr_exception_pc_o),
      .csr_exception_addr_o (csr_exception_addr_o),
      .csr_mret_o           (csr_mret_o),
      .redirect_valid_o     (redirect_valid_o),
      .redirect_pc_o        (redirect_pc_o),
      .drain_timeout_o      (drain_timeout_o),
      .dbg_state_o          (dbg_state_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] pulses();
      return {csr_ext_intr_o, csr_timer_intr_o, csr_exc_valid_o, csr_mret_o};
   endfunction

   // Entered one step after the sampling edge (FLUSH cycle) with pipe_idle_i=1.
   task automatic check_trap(input string tag, input logic [3:0] exp_pulse, input logic [3:0] exp_code,
                             input logic [31:0] exp_epc, input logic [31:0] exp_addr,
                             input logic [31:0] exp_redir);
      check_eq({tag, ".flush"}, {30'd0, stall_o, flush_o}, 32'h3);
      check_eq({tag, ".flush_pulses"}, {28'd0, pulses()}, 32'h0);
      tick();
      check_eq({tag, ".drain"}, {30'd0, stall_o, flush_o}, 32'h2);
      tick();
      check_eq({tag, ".commit_pulse"}, {28'd0, pulses()}, {28'd0, exp_pulse});
      check_eq({tag, ".cause"}, {28'd0, csr_exception_o}, {28'd0, exp_code});
      check_eq({tag, ".epc"}, csr_exception_pc_o, exp_epc);
      check_eq({tag, ".addr"}, csr_exception_addr_o, exp_addr);
      check_eq({tag, ".commit_redir"}, {31'd0, redirect_valid_o}, 32'h0);
      tick();
      check_eq({tag, ".redir_valid"}, {31'd0, redirect_valid_o}, 32'h1);
      check_eq({tag, ".redir_pc"}, redirect_pc_o, exp_redir);
      check_eq({tag, ".redir_pulses"}, {28'd0, pulses()}, 32'h0);
      check_eq({tag, ".redir_cause"}, {28'd0, csr_exception_o}, {28'd0, exp_code});
      tick();
      check_eq({tag, ".idle"}, {30'd0, stall_o, redirect_valid_o}, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      irq_ext_i = 1'b0; irq_timer_i = 1'b0; mstatus_mie_i = 1'b0;
      exc_valid_i = 1'b0; exc_code_i = '0; exc_pc_i = '0; exc_addr_i = '0;
      mret_i = 1'b0; commit_pc_i = '0; pipe_idle_i = 1'b1;
      mtvec_i = '0; mepc_i = '0;
      tick();
      tick();
      check_eq("rst.stall_flush", {30'd0, stall_o, flush_o}, 32'h0);
      check_eq("rst.pulses", {28'd0, pulses()}, 32'h0);
      check_eq("rst.redir", {31'd0, redirect_valid_o}, 32'h0);
      check_eq("rst.redir_pc", redirect_pc_o, 32'h0);
      check_eq("rst.timeout", {31'd0, drain_timeout_o}, 32'h0);
      check_eq("rst.cause", {28'd0, csr_exception_o}, 32'h0);
      check_eq("rst.epc", csr_exception_pc_o, 32'h0);
      check_eq("rst.addr", csr_exception_addr_o, 32'h0);
      rst_n = 1'b1;
      tick();
      check_eq("idle.stall", {31'd0, stall_o}, 32'h0);

      // Synchronous exception, non-vectored mtvec.
      exc_valid_i = 1'b1; exc_code_i = 4'd2; exc_pc_i = 32'h100; exc_addr_i = 32'hDEAD;
      mtvec_i = 32'h8000;
      tick();
      exc_valid_i = 1'b0;
      check_trap("exc", 4'b0010, 4'd2, 32'h100, 32'hDEAD, 32'h8000);

      // External IRQ, vectored: 0x8000 + 4*11.
      mstatus_mie_i = 1'b1; irq_ext_i = 1'b1; mtvec_i = 32'h8001; commit_pc_i = 32'h200;
      tick();
      irq_ext_i = 1'b0;
      check_trap("ext", 4'b1000, 4'd11, 32'h200, 32'h0, 32'h802C);

      // Timer beats a same-cycle exception: 0x8000 + 4*7.
      irq_timer_i = 1'b1; exc_valid_i = 1'b1; exc_code_i = 4'd3; exc_pc_i = 32'h500;
      commit_pc_i = 32'h300;
      tick();
      irq_timer_i = 1'b0; exc_valid_i = 1'b0;
      check_trap("timer", 4'b0100, 4'd7, 32'h300, 32'h0, 32'h801C);
      tick();
      check_eq("timer.exc_dropped", {31'd0, stall_o}, 32'h0);

      // Exception with vectored mtvec still goes to the base.
      exc_valid_i = 1'b1; exc_code_i = 4'd13; exc_pc_i = 32'h124; exc_addr_i = 32'h77;
      tick();
      exc_valid_i = 1'b0;
      check_trap("exc_vec", 4'b0010, 4'd13, 32'h124, 32'h77, 32'h8000);

      // Ext beats timer; vectored target wraps past 2^32.
      irq_ext_i = 1'b1; irq_timer_i = 1'b1; mtvec_i = 32'hFFFF_FFFD; commit_pc_i = 32'h600;
      tick();
      irq_ext_i = 1'b0; irq_timer_i = 1'b0;
      check_trap("wrap", 4'b1000, 4'd11, 32'h600, 32'h0, 32'h0000_0028);

      // mtvec mode 2'b11 is not vectored.
      irq_timer_i = 1'b1; mtvec_i = 32'h9003; commit_pc_i = 32'h700;
      tick();
      irq_timer_i = 1'b0;
      check_trap("mode3", 4'b0100, 4'd7, 32'h700, 32'h0, 32'h9000);

      // MRET returns to mepc.
      mret_i = 1'b1; mepc_i = 32'h344; mtvec_i = 32'h8000;
      tick();
      mret_i = 1'b0;
      check_trap("mret", 4'b0001, 4'd0, 32'h0, 32'h0, 32'h344);

      // IRQs are masked with MIE=0.
      mstatus_mie_i = 1'b0; irq_ext_i = 1'b1; irq_timer_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("mie0.quiet", {30'd0, stall_o, flush_o}, 32'h0);
      end
      irq_ext_i = 1'b0; irq_timer_i = 1'b0;

      // Drain timeout: pipe never idles; an exception mid-drain is ignored.
      pipe_idle_i = 1'b0; exc_valid_i = 1'b1; exc_code_i = 4'd5; exc_pc_i = 32'h400;
      exc_addr_i = 32'h44;
      tick();
      exc_valid_i = 1'b0;
      check_eq("to.flush", {31'd0, flush_o}, 32'h1);
      tick();
      for (int i = 1; i <= 15; i++) begin
         check_eq($sformatf("to.timeout_c%0d", i), {31'd0, drain_timeout_o}, (i == 15) ? 32'h1 : 32'h0);
         check_eq($sformatf("to.pulses_c%0d", i), {28'd0, pulses()}, 32'h0);
         exc_valid_i = (i == 5);
         exc_code_i  = (i == 5) ? 4'd9 : 4'd5;
         tick();
      end
      exc_valid_i = 1'b0;
      check_eq("to.commit", {28'd0, pulses()}, 32'h2);
      check_eq("to.cause", {28'd0, csr_exception_o}, 32'h5);
      check_eq("to.timeout_gone", {31'd0, drain_timeout_o}, 32'h0);
      tick();
      check_eq("to.redir_pc", redirect_pc_o, 32'h8000);
      tick();
      check_eq("to.idle", {31'd0, stall_o}, 32'h0);
      tick();
      check_eq("to.still_idle", {31'd0, stall_o}, 32'h0);

      // Pipe goes idle on the third DRAIN cycle: no timeout.
      exc_valid_i = 1'b1; exc_code_i = 4'd6; exc_pc_i = 32'h410; exc_addr_i = 32'h48;
      tick();
      exc_valid_i = 1'b0;
      tick();
      check_eq("d3.c1", {30'd0, drain_timeout_o, csr_exc_valid_o}, 32'h0);
      tick();
      check_eq("d3.c2", {30'd0, drain_timeout_o, csr_exc_valid_o}, 32'h0);
      tick();
      pipe_idle_i = 1'b1;
      check_eq("d3.c3", {30'd0, drain_timeout_o, csr_exc_valid_o}, 32'h0);
      check_eq("d3.c3_stall", {31'd0, stall_o}, 32'h1);
      tick();
      check_eq("d3.commit", {28'd0, pulses()}, 32'h2);
      check_eq("d3.epc", csr_exception_pc_o, 32'h410);
      tick();
      check_eq("d3.redir", {31'd0, redirect_valid_o}, 32'h1);
      tick();
      check_eq("d3.idle", {31'd0, stall_o}, 32'h0);

      // Asynchronous reset during DRAIN, then a fresh exception.
      pipe_idle_i = 1'b0; exc_valid_i = 1'b1; exc_code_i = 4'd4; exc_pc_i = 32'h420;
      exc_addr_i = 32'h4C;
      tick();
      exc_valid_i = 1'b0;
      tick();
      tick();
      check_eq("ar.in_drain", {31'd0, stall_o}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("ar.stall_flush", {30'd0, stall_o, flush_o}, 32'h0);
      check_eq("ar.pulses", {28'd0, pulses()}, 32'h0);
      check_eq("ar.redir_timeout", {30'd0, redirect_valid_o, drain_timeout_o}, 32'h0);
      check_eq("ar.latched", {28'd0, csr_exception_o} | csr_exception_pc_o | csr_exception_addr_o, 32'h0);
      tick();
      rst_n = 1'b1;
      pipe_idle_i = 1'b1;
      tick();
      check_eq("ar.idle", {31'd0, stall_o}, 32'h0);
      exc_valid_i = 1'b1; exc_code_i = 4'd7; exc_pc_i = 32'h430; exc_addr_i = 32'h50;
      mtvec_i = 32'hA000;
      tick();
      exc_valid_i = 1'b0;
      check_trap("post_rst", 4'b0010, 4'd7, 32'h430, 32'h50, 32'hA000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
